regfile_arbiter: RTL and testbench
==================================

// Module: regfile_arbiter
// PURPOSE
//  Shares the config register file between two requesters: port A (SPI host) and port B (internal/UART loader).
//  Round-robin arbitration; one transaction at a time.
//  Drives regfile write/read strobes and addresses; returns read data.
//  Each transaction completes with a one-cycle ack on the requesting port.
// PARAMETERS
//  NUMREGS  16  number of implemented registers; used by the range check
// PORTS
//  clk           in   1  system clock
//  reset         in   1  synchronous reset, active high
//  a_req/b_req   in   1  request; held until the matching ack
//  a_we/b_we     in   1  1 = write, 0 = read; held with req
//  a_addr/b_addr in   8  register address; held with req
//  a_wdata/b_wdata in 8  write data; held with req
//  a_ack/b_ack   out  1  one-cycle completion pulse
//  a_rdata/b_rdata out 8 read data; valid only in the ack cycle, else 0
//  a_err/b_err   out  1  address error, valid in the ack cycle (RF_ADDR_CHECK_EN)
//  rf_write      out  1  write strobe to the regfile
//  rf_read       out  1  read strobe to the regfile
//  rf_write_addr out  8  regfile write address
//  rf_write_data out  8  regfile write data
//  rf_read_addr  out  8  regfile read address
//  rf_read_data  in   8  regfile readback; registered, valid 1 cycle after rf_read
//  busy          out  1  high while state != IDLE
// BEHAVIOUR
//  All outputs are registered.
//  Reset values: all outputs 0, state IDLE, last_gnt = B, so A wins the first contention.
//  FSM IDLE -> ISSUE -> ACK -> IDLE. Fixed latency: req seen at edge N gives ack in cycle N+2.
//  IDLE:
//   - Only one req high: grant that port.
//   - Both high: grant the port != last_gnt.
//   - Latch the port's we/addr/wdata, update last_gnt, go to ISSUE.
//   - No req: stay in IDLE.
//  ISSUE (1 cycle):
//   - Write: rf_write=1, rf_write_addr and rf_write_data driven from the latched request.
//   - Read: rf_read=1, rf_read_addr driven from the latched address.
//   - Strobes are never both high. Go to ACK.
//  ACK (1 cycle):
//   - Granted port's ack=1.
//   - Read: rdata = rf_read_data. Write: rdata = 0.
//   - Go to IDLE.
//  Address buses hold their last value when no strobe is active. Strobes are 0 outside ISSUE.
//  The ungranted port's req is not sampled until the next IDLE. Max throughput is 1 transaction per 3 cycles.
//  Fairness: with both reqs held continuously, grants alternate A,B,A,B and neither port waits more than one transaction.
//  A requester may drop req in its ack cycle. Re-asserting in the next cycle is a new request.
//  req dropped before ack is a protocol violation. The latched transaction still completes and ack is still pulsed.
//  Reset asserted in any state:
//   - next edge: IDLE, strobes and acks 0, last_gnt = B
//   - the in-flight transaction is discarded with no ack
//   - a write strobe that was already issued is not undone
// CONFIGURATION
//  `RF_ADDR_CHECK_EN defined:
//   - In IDLE, a granted addr >= NUMREGS is flagged.
//   - ISSUE cycle runs with no strobe.
//   - ACK gives err=1, rdata=0. Latency is unchanged.
//  `RF_ADDR_CHECK_EN undefined:
//   - a_err/b_err tied 0.
//   - All addresses are forwarded unchanged to the regfile.
// TESTING
//  A write addr 3 data 0x5A:
//   - ISSUE: rf_write=1, rf_write_addr=3, rf_write_data=0x5A
//   - next cycle: a_ack=1, a_rdata=0
//  Then A read addr 3: ISSUE rf_read=1, rf_read_addr=3; ACK a_ack=1, a_rdata=0x5A.
//  After reset, A and B both req in the same cycle (A wr 1<-0x11, B wr 2<-0x22):
//   - A is served first, a_ack at cycle 2
//   - B is served next, b_ack at cycle 5
//   - B's request stays stable throughout
//  Both reqs held for 4 transactions: ack order A,B,A,B, acks exactly 3 cycles apart.
//  Reset asserted during ISSUE of a B read: no b_ack, busy=0 next cycle; the next contention goes to A.
//  RF_ADDR_CHECK_EN, NUMREGS=16, A read addr 0x20:
//   - rf_read stays 0
//   - a_ack=1, a_err=1, a_rdata=0 at cycle 2
//  Same test without the macro: rf_read=1 with addr 0x20, a_err=0.

Source files
------------

// File: rtl/regfile_arbiter.sv
// Round-robin arbiter sharing the config regfile between port A and port B; req at edge N gives ack in cycle N+2.
// One transaction in flight; the losing port waits with req held until the next IDLE. `RF_ADDR_CHECK_EN enables the range check.
module regfile_arbiter #(
  parameter int NUMREGS = 16
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_a_req,
  input  logic       i_a_we,
  input  logic [7:0] i_a_addr,
  input  logic [7:0] i_a_wdata,
  input  logic       i_b_req,
  input  logic       i_b_we,
  input  logic [7:0] i_b_addr,
  input  logic [7:0] i_b_wdata,
  output logic       o_a_ack,
  output logic [7:0] o_a_rdata,
  output logic       o_a_err,
  output logic       o_b_ack,
  output logic [7:0] o_b_rdata,
  output logic       o_b_err,
  output logic       o_rf_write,
  output logic       o_rf_read,
  output logic [7:0] o_rf_write_addr,
  output logic [7:0] o_rf_write_data,
  output logic [7:0] o_rf_read_addr,
  input  logic [7:0] i_rf_read_data,
  output logic       o_busy
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_ACK   = 2'd2;

  logic [1:0] r_state;
  logic       r_last_b;
  logic       r_gnt_b;
  logic       r_we;
  logic       r_bad;
  logic       r_a_ack;
  logic       r_b_ack;
  logic       r_rf_write;
  logic       r_rf_read;
  logic [7:0] r_rf_write_addr;
  logic [7:0] r_rf_write_data;
  logic [7:0] r_rf_read_addr;
  logic       r_busy;

  logic       w_any_req;
  logic       w_pick_b;
  logic       w_sel_we;
  logic [7:0] w_sel_addr;
  logic [7:0] w_sel_wdata;
  logic       w_addr_oob;
  logic       w_sel_bad;

  // Under contention the port that did not win last time is granted.
  assign w_any_req   = i_a_req | i_b_req;
  assign w_pick_b    = i_b_req & (~i_a_req | ~r_last_b);
  assign w_sel_we    = w_pick_b ? i_b_we    : i_a_we;
  assign w_sel_addr  = w_pick_b ? i_b_addr  : i_a_addr;
  assign w_sel_wdata = w_pick_b ? i_b_wdata : i_a_wdata;
  assign w_addr_oob  = (32'(w_sel_addr) >= 32'(NUMREGS));

`ifdef RF_ADDR_CHECK_EN
  logic r_a_err;
  logic r_b_err;

  assign w_sel_bad = w_addr_oob;
  assign o_a_err   = r_a_err;
  assign o_b_err   = r_b_err;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_a_err <= 1'b0;
      r_b_err <= 1'b0;
    end else if (r_state == S_ISSUE) begin
      r_a_err <= ~r_gnt_b & r_bad;
      r_b_err <=  r_gnt_b & r_bad;
    end else begin
      r_a_err <= 1'b0;
      r_b_err <= 1'b0;
    end
  end
`else
  // Range check compiled out: every address is forwarded as-is.
  assign w_sel_bad = w_addr_oob & 1'b0;
  assign o_a_err   = 1'b0;
  assign o_b_err   = 1'b0;
`endif

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state         <= S_IDLE;
      r_last_b        <= 1'b1;
      r_gnt_b         <= 1'b0;
      r_we            <= 1'b0;
      r_bad           <= 1'b0;
      r_a_ack         <= 1'b0;
      r_b_ack         <= 1'b0;
      r_rf_write      <= 1'b0;
      r_rf_read       <= 1'b0;
      r_rf_write_addr <= 8'd0;
      r_rf_write_data <= 8'd0;
      r_rf_read_addr  <= 8'd0;
      r_busy          <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any_req) begin
            r_gnt_b  <= w_pick_b;
            r_last_b <= w_pick_b;
            r_we     <= w_sel_we;
            r_bad    <= w_sel_bad;
            r_busy   <= 1'b1;
            r_state  <= S_ISSUE;
            // Strobe and buses are registered here so they appear in the ISSUE cycle.
            if (!w_sel_bad) begin
              if (w_sel_we) begin
                r_rf_write      <= 1'b1;
                r_rf_write_addr <= w_sel_addr;
                r_rf_write_data <= w_sel_wdata;
              end else begin
                r_rf_read       <= 1'b1;
                r_rf_read_addr  <= w_sel_addr;
              end
            end
          end
        end
        S_ISSUE: begin
          r_rf_write <= 1'b0;
          r_rf_read  <= 1'b0;
          r_a_ack    <= ~r_gnt_b;
          r_b_ack    <=  r_gnt_b;
          r_state    <= S_ACK;
        end
        S_ACK: begin
          r_a_ack <= 1'b0;
          r_b_ack <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // The regfile's own output register supplies read data in the ack cycle; only the gating is added here.
  assign o_a_rdata = (r_a_ack && !r_we && !r_bad) ? i_rf_read_data : 8'd0;
  assign o_b_rdata = (r_b_ack && !r_we && !r_bad) ? i_rf_read_data : 8'd0;

  assign o_a_ack         = r_a_ack;
  assign o_b_ack         = r_b_ack;
  assign o_rf_write      = r_rf_write;
  assign o_rf_read       = r_rf_read;
  assign o_rf_write_addr = r_rf_write_addr;
  assign o_rf_write_data = r_rf_write_data;
  assign o_rf_read_addr  = r_rf_read_addr;
  assign o_busy          = r_busy;

endmodule

// File: tb/tb_regfile_arbiter.sv
// Bench for regfile_arbiter: directed scenarios plus random traffic checked every cycle against a
// transaction-level schedule model (grant at cycle k -> strobe at k+1, ack at k+2, next grant from k+3).
module tb_regfile_arbiter;

`ifdef RF_ADDR_CHECK_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif
  localparam int NREGS = 16;

  logic       clk = 1'b0;
  logic       reset;
  logic       a_req, a_we, b_req, b_we;
  logic [7:0] a_addr, a_wdata, b_addr, b_wdata;
  logic       a_ack, a_err, b_ack, b_err;
  logic [7:0] a_rdata, b_rdata;
  logic       rf_write, rf_read, busy;
  logic [7:0] rf_waddr, rf_wdata, rf_raddr;
  logic [7:0] rf_rd = 8'h00;
  logic [7:0] rf_mem [256] = '{default: 8'h00};

  always #5 clk = ~clk;

  regfile_arbiter #(.NUMREGS(NREGS)) dut (
    .i_clk(clk), .i_reset(reset),
    .i_a_req(a_req), .i_a_we(a_we), .i_a_addr(a_addr), .i_a_wdata(a_wdata),
    .i_b_req(b_req), .i_b_we(b_we), .i_b_addr(b_addr), .i_b_wdata(b_wdata),
    .o_a_ack(a_ack), .o_a_rdata(a_rdata), .o_a_err(a_err),
    .o_b_ack(b_ack), .o_b_rdata(b_rdata), .o_b_err(b_err),
    .o_rf_write(rf_write), .o_rf_read(rf_read),
    .o_rf_write_addr(rf_waddr), .o_rf_write_data(rf_wdata), .o_rf_read_addr(rf_raddr),
    .i_rf_read_data(rf_rd), .o_busy(busy)
  );

  // Register file: write on strobe, registered readback one cycle after rf_read.
  always @(posedge clk) begin
    if (rf_write) rf_mem[rf_waddr] <= rf_wdata;
    if (rf_read)  rf_rd <= rf_mem[rf_raddr];
  end

  int checks = 0;
  int errors = 0;
  int k = 0;

  // Reference model state
  int         m_free, m_issue, m_ack;
  bit         m_gb, m_we, m_bad, m_lastb, m_rst;
  logic [7:0] m_addr, m_wdata, m_rd;
  logic [7:0] e_waddr, e_wdata, e_raddr;
  logic [7:0] m_mem [256] = '{default: 8'h00};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got 0x%0h expected 0x%0h", nm, k, act, exp);
    end
  endtask

  task automatic model_decide();
    m_rst = reset;
    if (!reset && k >= m_free && (a_req || b_req)) begin
      m_gb    = b_req && (!a_req || !m_lastb);
      m_lastb = m_gb;
      m_we    = m_gb ? b_we    : a_we;
      m_addr  = m_gb ? b_addr  : a_addr;
      m_wdata = m_gb ? b_wdata : a_wdata;
      m_bad   = CHK_EN && (int'(m_addr) >= NREGS);
      m_issue = k + 1;
      m_ack   = k + 2;
      m_free  = k + 3;
    end
  endtask

  task automatic model_compare();
    bit is_iss, is_ack, ga, gb;
    is_iss = (k == m_issue);
    is_ack = (k == m_ack);
    if (is_iss && !m_bad) begin
      if (m_we) begin
        e_waddr = m_addr;
        e_wdata = m_wdata;
      end else begin
        e_raddr = m_addr;
        m_rd    = m_mem[m_addr];
      end
    end
    ga = is_ack && !m_gb;
    gb = is_ack &&  m_gb;
    chk("rf_write", rf_write, is_iss && m_we && !m_bad);
    chk("rf_read",  rf_read,  is_iss && !m_we && !m_bad);
    chk("rf_write_addr", rf_waddr, e_waddr);
    chk("rf_write_data", rf_wdata, e_wdata);
    chk("rf_read_addr",  rf_raddr, e_raddr);
    chk("busy",  busy,  is_iss || is_ack);
    chk("a_ack", a_ack, ga);
    chk("b_ack", b_ack, gb);
    chk("a_err", a_err, ga && m_bad);
    chk("b_err", b_err, gb && m_bad);
    chk("a_rdata", a_rdata, (ga && !m_we && !m_bad) ? m_rd : 8'h00);
    chk("b_rdata", b_rdata, (gb && !m_we && !m_bad) ? m_rd : 8'h00);
  endtask

  task automatic model_post();
    if (k == m_issue && m_we && !m_bad) m_mem[m_addr] = m_wdata;
    if (m_rst) begin
      if (m_issue > k) m_issue = -10;
      if (m_ack > k)   m_ack   = -10;
      m_free  = k + 1;
      m_lastb = 1'b1;
      e_waddr = 8'h00;
      e_wdata = 8'h00;
      e_raddr = 8'h00;
    end
  endtask

  task automatic run();
    model_decide();
    @(negedge clk);
    model_compare();
    model_post();
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
    k++;
  endtask

  task automatic drive(input bit port_b, input bit req, input bit we,
                       input logic [7:0] addr, input logic [7:0] wdata);
    if (port_b) begin
      b_req = req; b_we = we; b_addr = addr; b_wdata = wdata;
    end else begin
      a_req = req; a_we = we; a_addr = addr; a_wdata = wdata;
    end
  endtask

  function automatic logic [7:0] rnd_addr();
    return ($urandom_range(0, 7) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 15));
  endfunction

  bit a_pend, b_pend;

  initial begin
    reset = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    drive(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
    m_free = 0; m_issue = -10; m_ack = -10; m_lastb = 1'b1;
    m_gb = 0; m_we = 0; m_bad = 0; m_rst = 0;
    m_addr = 0; m_wdata = 0; m_rd = 0;
    e_waddr = 0; e_wdata = 0; e_raddr = 0;
    @(posedge clk); #1;
    reset = 1'b0;
    k = 0;

    // A write 3 <- 0x5A, then A read 3
    drive(1'b0, 1'b1, 1'b1, 8'd3, 8'h5A);
    run(); chk("lit_reset_busy", busy, 0); chk("lit_reset_ack", a_ack, 0); nxt();
    run(); chk("lit_wr_strobe", rf_write, 1); chk("lit_wr_addr", rf_waddr, 3);
    chk("lit_wr_data", rf_wdata, 8'h5A); nxt();
    a_req = 1'b0;
    run(); chk("lit_wr_ack", a_ack, 1); chk("lit_wr_rdata", a_rdata, 0); nxt();
    drive(1'b0, 1'b1, 1'b0, 8'd3, 8'h00);
    run(); nxt();
    run(); chk("lit_rd_strobe", rf_read, 1); chk("lit_rd_addr", rf_raddr, 3); nxt();
    a_req = 1'b0;
    run(); chk("lit_rd_ack", a_ack, 1); chk("lit_rd_rdata", a_rdata, 8'h5A); nxt();

    // Reset, then simultaneous writes from both ports: A first, B three cycles later
    reset = 1'b1; run(); nxt(); reset = 1'b0;
    drive(1'b0, 1'b1, 1'b1, 8'd1, 8'h11);
    drive(1'b1, 1'b1, 1'b1, 8'd2, 8'h22);
    run(); nxt();
    run(); nxt();
    a_req = 1'b0;
    run(); chk("lit_cont_a_ack", a_ack, 1); chk("lit_cont_b_idle", b_ack, 0); nxt();
    run(); nxt();
    run(); nxt();
    b_req = 1'b0;
    run(); chk("lit_cont_b_ack", b_ack, 1); chk("lit_cont_a_idle", a_ack, 0); nxt();

    // Both held: acks alternate A,B,A,B three cycles apart
    drive(1'b0, 1'b1, 1'b0, 8'd1, 8'h00);
    drive(1'b1, 1'b1, 1'b0, 8'd2, 8'h00);
    for (int i = 0; i < 12; i++) begin
      if (i == 8)  a_req = 1'b0;
      if (i == 11) b_req = 1'b0;
      run();
      chk("lit_fair_a_ack", a_ack, (i == 2 || i == 8));
      chk("lit_fair_b_ack", b_ack, (i == 5 || i == 11));
      chk("lit_fair_a_rdata", a_rdata, (i == 2 || i == 8) ? 8'h11 : 8'h00);
      chk("lit_fair_b_rdata", b_rdata, (i == 5 || i == 11) ? 8'h22 : 8'h00);
      nxt();
    end

    // Reset during ISSUE of a B read: no ack, A wins the next contention
    drive(1'b1, 1'b1, 1'b0, 8'd2, 8'h00);
    run(); nxt();
    reset = 1'b1;
    run(); chk("lit_rst_issue_rd", rf_read, 1); chk("lit_rst_issue_addr", rf_raddr, 2); nxt();
    reset = 1'b0;
    drive(1'b0, 1'b1, 1'b0, 8'd1, 8'h00);
    run(); chk("lit_rst_no_back", b_ack, 0); chk("lit_rst_busy", busy, 0); nxt();
    run(); nxt();
    a_req = 1'b0;
    run(); chk("lit_rst_a_first", a_ack, 1); chk("lit_rst_b_wait", b_ack, 0);
    chk("lit_rst_a_rdata", a_rdata, 8'h11); nxt();
    run(); nxt();
    run(); nxt();
    b_req = 1'b0;
    run(); chk("lit_rst_b_ack", b_ack, 1); chk("lit_rst_b_rdata", b_rdata, 8'h22); nxt();

    // Out-of-range read 0x20
    drive(1'b0, 1'b1, 1'b0, 8'h20, 8'h00);
    run(); nxt();
    run(); chk("lit_oob_rd", rf_read, CHK_EN ? 0 : 1);
    chk("lit_oob_addr", rf_raddr, CHK_EN ? 8'd2 : 8'h20); nxt();
    a_req = 1'b0;
    run(); chk("lit_oob_ack", a_ack, 1); chk("lit_oob_err", a_err, CHK_EN ? 1 : 0);
    chk("lit_oob_rdata", a_rdata, 0); nxt();

    // Random traffic with occasional resets
    a_pend = 0;
    b_pend = 0;
    for (int n = 0; n < 3000; n++) begin
      reset = ($urandom_range(0, 199) == 0);
      if (!a_pend && $urandom_range(0, 2) == 0) begin
        a_pend = 1;
        drive(1'b0, 1'b1, 1'($urandom_range(0, 1)), rnd_addr(), 8'($urandom));
      end
      if (!b_pend && $urandom_range(0, 2) == 0) begin
        b_pend = 1;
        drive(1'b1, 1'b1, 1'($urandom_range(0, 1)), rnd_addr(), 8'($urandom));
      end
      a_req = a_pend;
      b_req = b_pend;
      run();
      if (a_ack) a_pend = 0;
      if (b_ack) b_pend = 0;
      nxt();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
